// File: rtl/if_stage_sequencer_pkg.sv
// Shared fetch-stage types and constants (also used by decode and the hazard unit).
package if_stage_sequencer_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned INSTR_BYTES       = 4;
    localparam int unsigned MEM_BYTES_DEFAULT = 60;

    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // IF/ID payload carried alongside the valid bit
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } ifid_payload_t;

endpackage

// File: rtl/if_stage_sequencer_ifid_pipe_reg.sv
// IF/ID pipeline register with bubble / hold / load controls (bubble > hold > load).
// Ports:
//   clk, rst_n    clock, async active-low reset
//   bubble_i      clear valid and instr (pc fields kept)
//   hold_i        keep every field
//   load_i        capture payload_i as a valid instruction
//   payload_i     {pc, pc4, instr} to capture
//   valid_o       register holds a real instruction
//   payload_o     registered {pc, pc4, instr}
module ifid_pipe_reg
    import if_stage_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble_i,
    input  logic          hold_i,
    input  logic          load_i,
    input  ifid_payload_t payload_i,
    output logic          valid_o,
    output ifid_payload_t payload_o
);

    logic          valid_q, valid_d;
    ifid_payload_t payload_q, payload_d;

    // Next-value selection; neither load nor hold means an implicit bubble
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (bubble_i) begin
            valid_d         = 1'b0;
            payload_d.instr = '0;
        end else if (hold_i) begin
            valid_d   = valid_q;
            payload_d = payload_q;
        end else if (load_i) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
        end else begin
            valid_d         = 1'b0;
            payload_d.instr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/if_stage_sequencer.sv
// Fetch-stage controller: owns the PC, addresses instruction memory, fills IF/ID,
// traps bad fetch addresses, stops on the halt word and counts valid fetches.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   stall, flush                 hazard-unit hold / squash requests
//   redirect_valid, redirect_pc  taken branch/jump target
//   imem_addr, imem_rdata        instruction memory (same-cycle read)
//   ifid_valid/pc/pc4/instr      IF/ID register contents
//   pc_fault, halted             FAULT / HALT state indication
//   fetch_count                  instructions written valid into IF/ID
module if_stage_sequencer
    import if_stage_sequencer_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        pc_fault,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_ok;
    logic            ifid_bubble, ifid_hold, ifid_load;
    ifid_payload_t   ifid_in, ifid_out;

    // 33-bit range check so addresses near 2^32 cannot wrap into range
    assign fetch_ok = (pc_q[1:0] == 2'b00) &&
                      ((33'(pc_q) + 33'd3) < 33'(MEM_BYTES));
    assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

    // Next-state, next-PC, counter and IF/ID control
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        ifid_bubble = flush || redirect_valid;
        ifid_hold   = 1'b0;
        ifid_load   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (!fetch_ok) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d = pc_plus4;
                    if (!flush) begin
                        ifid_load = 1'b1;
                        cnt_d     = cnt_q + 32'd1;
                        // Halt word is delivered to IF/ID; PC stays on it
                        if (imem_rdata == HALT_WORD) begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                    end
                end
            end
            ST_FAULT, ST_HALT: begin
                // Only a redirect leaves these states; IF/ID drains to bubbles
                if (redirect_valid) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_pc;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifid_in = '{pc: pc_q, pc4: pc_plus4, instr: imem_rdata};

    ifid_pipe_reg u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble_i  (ifid_bubble),
        .hold_i    (ifid_hold),
        .load_i    (ifid_load),
        .payload_i (ifid_in),
        .valid_o   (ifid_valid),
        .payload_o (ifid_out)
    );

    assign imem_addr   = pc_q;
    assign ifid_pc     = ifid_out.pc;
    assign ifid_pc4    = ifid_out.pc4;
    assign ifid_instr  = ifid_out.instr;
    assign pc_fault    = (state_q == ST_FAULT);
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = cnt_q;

endmodule
